// File: rtl/pe_pkg.sv
// Shared constants for the PE stream feeder: default parameter values and
// the FSM state encoding used by pe_stream_feeder.
package pe_pkg;

   localparam int DEF_DATA_WIDTH = 4;
   localparam int DEF_ACC_WIDTH  = 16;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_PE_LATENCY = 3;

   // Feeder FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

endpackage

// File: rtl/pe_operand_buf.sv
// Dual operand buffer (A and B) for the PE stream feeder.
// One write port steered by wr_sel, combinational read of A and B at the
// same index. Contents are deliberately not reset so operands survive a
// clr_n pulse and can be reused by later commands.
module pe_operand_buf
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
)(
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_a,
   output logic [DATA_WIDTH-1:0]    rd_b
);

   logic [DATA_WIDTH-1:0] mem_a [DEPTH];
   logic [DATA_WIDTH-1:0] mem_b [DEPTH];

   // Single write port: wr_sel picks the A or B bank
   always_ff @(posedge clk) begin
      if (wr_en && !wr_sel) mem_a[wr_addr] <= wr_data;
      if (wr_en &&  wr_sel) mem_b[wr_addr] <= wr_data;
   end

   assign rd_a = mem_a[rd_addr];
   assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/pe_stream_feeder.sv
// PE stream feeder: streams A[i]/B[i] operand pairs into a dot-product PE
// as registered beats (start on beat 0, last on beat len-1), then waits for
// the PE result, captures it in res and pulses done.
// Optional build macro PE_FEEDER_WATCHDOG_EN adds a WAIT-state watchdog that
// sets the sticky err flag and aborts to IDLE when the PE never answers.
// Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready;
// cmd_ready is high only in IDLE, and cmd_len is sampled on that cycle.
module pe_stream_feeder
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int PE_LATENCY = DEF_PE_LATENCY
)(
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     cmd_valid,
   input  logic [$clog2(DEPTH):0]   cmd_len,
   output logic                     cmd_ready,
   input  logic                     hold,
   output logic                     pe_start,
   output logic                     pe_valid_in,
   output logic                     pe_last,
   output logic [DATA_WIDTH-1:0]    pe_a,
   output logic [DATA_WIDTH-1:0]    pe_b,
   input  logic [ACC_WIDTH-1:0]     pe_c,
   input  logic                     pe_output_valid,
   output logic [ACC_WIDTH-1:0]     res,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

   logic [1:0]            state;
   logic [LW-1:0]         len;
   logic [LW-1:0]         idx;
   logic [LW-1:0]         len_clamped;
   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;
   logic                  accept;
   logic                  buf_we;
   logic                  beat;
   logic                  last_beat;
   logic                  wd_fire;

   assign cmd_ready   = (state == ST_IDLE);
   assign accept      = cmd_valid & cmd_ready;
   assign buf_we      = wr_en & (state == ST_IDLE);
   assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   assign beat        = (state == ST_STREAM) & ~hold;
   assign last_beat   = beat & (idx == (len - 1'b1));
   assign dbg_state   = state;

   pe_operand_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_sel  (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx[AW-1:0]),
      .rd_a    (rd_a),
      .rd_b    (rd_b)
   );

`ifdef PE_FEEDER_WATCHDOG_EN
   localparam int WDW = $clog2(PE_LATENCY + 3);
   localparam logic [WDW-1:0] WD_LAST = WDW'(PE_LATENCY + 1);

   logic [WDW-1:0] wd_cnt;

   // Fires on the cycle the count reaches PE_LATENCY+2 cycles spent in WAIT
   assign wd_fire = (state == ST_WAIT) & ~pe_output_valid & (wd_cnt == WD_LAST);

   // Watchdog count of WAIT cycles, cleared on the last beat; err is sticky
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wd_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (last_beat)
            wd_cnt <= '0;
         else if (state == ST_WAIT && !pe_output_valid)
            wd_cnt <= wd_cnt + 1'b1;
         if (wd_fire)
            err <= 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
   assign err     = 1'b0;
`endif

   // Control FSM: command acceptance, beat index, result capture and done
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= ST_IDLE;
         len   <= '0;
         idx   <= '0;
         res   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (len_clamped == '0) begin
                     // Empty vector: answer immediately, no beats
                     res  <= '0;
                     done <= 1'b1;
                  end else begin
                     len   <= len_clamped;
                     idx   <= '0;
                     state <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (beat) begin
                  idx <= idx + 1'b1;
                  if (last_beat) state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (pe_output_valid) begin
                  res   <= pe_c;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else if (wd_fire) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered beat outputs; operands hold their value between beats
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pe_valid_in <= 1'b0;
         pe_start    <= 1'b0;
         pe_last     <= 1'b0;
         pe_a        <= '0;
         pe_b        <= '0;
      end else begin
         pe_valid_in <= beat;
         pe_start    <= beat & (idx == '0);
         pe_last     <= last_beat;
         if (beat) begin
            pe_a <= rd_a;
            pe_b <= rd_b;
         end
      end
   end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Testbench for pe_stream_feeder: directed steps with a beat/result
// scoreboard and a behavioural dot-product PE model.
module tb_pe_stream_feeder;

   localparam int DW    = 4;
   localparam int AccW  = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int LW    = 5;
   localparam int PL    = 3;

   logic            clk = 1'b0;
   logic            clr_n;
   logic            wr_en;
   logic            wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            cmd_valid;
   logic [LW-1:0]   cmd_len;
   logic            cmd_ready;
   logic            hold;
   logic            pe_start;
   logic            pe_valid_in;
   logic            pe_last;
   logic [DW-1:0]   pe_a;
   logic [DW-1:0]   pe_b;
   logic [AccW-1:0] pe_c;
   logic            pe_output_valid;
   logic [AccW-1:0] res;
   logic            done;
   logic            err;
   logic [1:0]      dbg_state;

   pe_stream_feeder dut (
      .clk             (clk),
      .clr_n           (clr_n),
      .wr_en           (wr_en),
      .wr_sel          (wr_sel),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .cmd_valid       (cmd_valid),
      .cmd_len         (cmd_len),
      .cmd_ready       (cmd_ready),
      .hold            (hold),
      .pe_start        (pe_start),
      .pe_valid_in     (pe_valid_in),
      .pe_last         (pe_last),
      .pe_a            (pe_a),
      .pe_b            (pe_b),
      .pe_c            (pe_c),
      .pe_output_valid (pe_output_valid),
      .res             (res),
      .done            (done),
      .err             (err),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   int vectors     = 0;
   int miscompares = 0;

   logic [9:0]      exp_beat_q [$];
   logic [AccW-1:0] exp_res_q  [$];
   int              beat_cyc_q [$];
   logic [DW-1:0]   mdl_a [DEPTH];
   logic [DW-1:0]   mdl_b [DEPTH];
   logic [AccW-1:0] last_res = '0;
   logic [9:0]      mon_e;
   int done_cnt   = 0;
   int start_cnt  = 0;
   int beats_seen = 0;
   int spurious   = 0;
   int last_cyc   = 0;
   int done_cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- PE model ----------------
   logic            pe_silent = 1'b0;
   logic [AccW-1:0] pe_acc;
   logic [AccW-1:0] pe_pending;
   int              pe_cnt;

   always @(posedge clk or negedge clr_n) begin
      logic [AccW-1:0] acc_n;
      if (!clr_n) begin
         pe_acc          <= '0;
         pe_pending      <= '0;
         pe_cnt          <= 0;
         pe_output_valid <= 1'b0;
         pe_c            <= '0;
      end else begin
         pe_output_valid <= 1'b0;
         if (pe_cnt > 0) begin
            pe_cnt <= pe_cnt - 1;
            if (pe_cnt == 1 && !pe_silent) begin
               pe_output_valid <= 1'b1;
               pe_c            <= pe_pending;
            end
         end
         if (pe_valid_in) begin
            acc_n = (pe_start ? '0 : pe_acc) + AccW'(pe_a) * AccW'(pe_b);
            pe_acc <= acc_n;
            if (pe_last) begin
               pe_pending <= acc_n;
               pe_cnt     <= PL - 1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (clr_n) begin
         if (pe_valid_in) begin
            beats_seen++;
            beat_cyc_q.push_back(cyc);
            if (pe_start) start_cnt++;
            if (pe_last) last_cyc = cyc;
            if (exp_beat_q.size() == 0) spurious++;
            else begin
               mon_e = exp_beat_q.pop_front();
               check("beat", {22'd0, pe_start, pe_last, pe_a, pe_b}, {22'd0, mon_e});
            end
         end else begin
            check("ctrl_outside_beat", {30'd0, pe_start, pe_last}, 32'd0);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_res_q.size() == 0) spurious++;
            else check("res", {16'd0, res}, {16'd0, exp_res_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_buf(input logic sel, input int addr, input logic [DW-1:0] d, input bit upd);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AW-1:0]; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (upd) begin
         if (sel) mdl_b[addr] = d;
         else     mdl_a[addr] = d;
      end
   endtask

   // mode 0: no result expected, 1: dot product, 2: previous res unchanged
   task automatic push_expect(input int len, input int mode);
      int l;
      logic [AccW-1:0] sum;
      l = (len > DEPTH) ? DEPTH : len;
      sum = '0;
      for (int i = 0; i < l; i++) begin
         exp_beat_q.push_back({(i == 0), (i == l - 1), mdl_a[i], mdl_b[i]});
         sum += AccW'(mdl_a[i]) * AccW'(mdl_b[i]);
      end
      if (mode == 1) begin
         exp_res_q.push_back(sum);
         last_res = sum;
      end else if (mode == 2) begin
         exp_res_q.push_back(last_res);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
      check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
   endtask

   // acc_cyc: value of cyc at the accepting edge
   task automatic send_cmd(input int len, input int mode, output int acc_cyc, output int d0);
      wait_ready();
      push_expect(len, mode);
      d0 = done_cnt;
      beat_cyc_q.delete();
      cmd_valid = 1'b1; cmd_len = len[LW-1:0];
      @(posedge clk); #1;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 400) begin @(posedge clk); #1; n++; end
      check("done_seen", {31'd0, (done_cnt != d0)}, 32'd1);
      repeat (6) begin @(posedge clk); #1; end
      check("done_once", done_cnt - d0, 32'd1);
      check("beats_left", exp_beat_q.size(), 32'd0);
      check("res_left", exp_res_q.size(), 32'd0);
   endtask

   task automatic run_cmd(input int len);
      int acc, d0;
      send_cmd(len, 1, acc, d0);
      wait_done(d0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int acc, d0, s0, n;
      clr_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      cmd_valid = 1'b0; cmd_len = '0; hold = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin mdl_a[i] = '0; mdl_b[i] = '0; end

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("rst_outs", {pe_start, pe_valid_in, pe_last, pe_a, pe_b, done, err},
            32'd0);
      check("rst_res", {16'd0, res}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk); clr_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

      // Clear all buffer entries so the model matches
      for (int i = 0; i < DEPTH; i++) begin
         write_buf(1'b0, i, 4'd0, 1'b1);
         write_buf(1'b1, i, 4'd0, 1'b1);
      end

      // A=B={1..4}, len 4 -> 0x001E; first beat one cycle after acceptance
      for (int i = 0; i < 4; i++) begin
         write_buf(1'b0, i, 4'(i + 1), 1'b1);
         write_buf(1'b1, i, 4'(i + 1), 1'b1);
      end
      s0 = start_cnt;
      send_cmd(4, 1, acc, d0);
      wait_done(d0);
      check("res_1e", {16'd0, res}, 32'h1e);
      check("first_beat_lat", beat_cyc_q[0] - acc, 32'd1);
      check("back_to_back", beat_cyc_q[3] - beat_cyc_q[0], 32'd3);
      check("start_once", start_cnt - s0, 32'd1);

      // Single beat with start=last, 0xF*0xF = 0xE1
      write_buf(1'b0, 0, 4'hf, 1'b1);
      write_buf(1'b1, 0, 4'hf, 1'b1);
      run_cmd(1);
      check("res_e1", {16'd0, res}, 32'he1);

      // Empty vector: no beats, done in the cycle after acceptance, res 0
      n = beats_seen;
      send_cmd(0, 1, acc, d0);
      wait_done(d0);
      check("len0_latency", done_cyc - acc, 32'd0);
      check("len0_no_beats", beats_seen - n, 32'd0);
      check("len0_res", {16'd0, res}, 32'd0);

      // Hold for two cycles after beat 1: beats 0,1,gap,gap,2,3
      write_buf(1'b0, 0, 4'd1, 1'b1);
      write_buf(1'b1, 0, 4'd1, 1'b1);
      s0 = start_cnt;
      send_cmd(4, 1, acc, d0);
      @(posedge clk);
      @(posedge clk); #1;
      hold = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      hold = 1'b0;
      wait_done(d0);
      check("hold_nbeats", beat_cyc_q.size(), 32'd4);
      check("hold_gap01", beat_cyc_q[1] - beat_cyc_q[0], 32'd1);
      check("hold_gap12", beat_cyc_q[2] - beat_cyc_q[1], 32'd3);
      check("hold_gap23", beat_cyc_q[3] - beat_cyc_q[2], 32'd1);
      check("hold_start_once", start_cnt - s0, 32'd1);
      check("hold_res", {16'd0, res}, 32'h1e);

      // Random fill, oversize length clamped to DEPTH, write while busy dropped
      for (int i = 0; i < DEPTH; i++) begin
         write_buf(1'b0, i, 4'($urandom_range(0, 15)), 1'b1);
         write_buf(1'b1, i, 4'($urandom_range(0, 15)), 1'b1);
      end
      send_cmd(20, 1, acc, d0);
      write_buf(1'b0, 5, ~mdl_a[5], 1'b0);
      wait_done(d0);
      check("clamp_nbeats", beat_cyc_q.size(), 32'd16);

      // Write and command in the same cycle: write lands first
      wait_ready();
      mdl_a[0] = 4'd7;
      push_expect(1, 1);
      d0 = done_cnt;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 4'd7;
      cmd_valid = 1'b1; cmd_len = 5'd1;
      @(posedge clk); #1;
      wr_en = 1'b0; cmd_valid = 1'b0;
      wait_done(d0);

`ifdef PE_FEEDER_WATCHDOG_EN
      // PE never answers: err set, done PE_LATENCY+2 cycles after WAIT entry
      pe_silent = 1'b1;
      send_cmd(2, 2, acc, d0);
      wait_done(d0);
      check("wd_err", {31'd0, err}, 32'd1);
      check("wd_latency", done_cyc - last_cyc, 32'(PL + 2));
      pe_silent = 1'b0;
      run_cmd(3);
      check("wd_err_sticky", {31'd0, err}, 32'd1);
`else
      // PE never answers: WAIT holds indefinitely, err stays 0
      pe_silent = 1'b1;
      send_cmd(2, 0, acc, d0);
      repeat (30) begin @(posedge clk); #1; end
      check("wait_no_done", done_cnt - d0, 32'd0);
      check("wait_state", {30'd0, dbg_state}, 32'd2);
      check("wait_not_ready", {31'd0, cmd_ready}, 32'd0);
      check("no_err", {31'd0, err}, 32'd0);
      check("wait_beats_left", exp_beat_q.size(), 32'd0);
      clr_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); clr_n = 1'b1; pe_silent = 1'b0;
      @(posedge clk); #1;
      check("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
`endif

      // Reset at beat 2 of 16: outputs clear at once, no done, then rerun
      for (int i = 0; i < DEPTH; i++) begin
         write_buf(1'b0, i, 4'($urandom_range(1, 15)), 1'b1);
         write_buf(1'b1, i, 4'($urandom_range(1, 15)), 1'b1);
      end
      n = beats_seen;
      send_cmd(16, 1, acc, d0);
      s0 = 0;
      while (beats_seen < n + 3 && s0 < 100) begin @(negedge clk); s0++; end
      check("reached_beat2", beats_seen - n, 32'd3);
      #2 clr_n = 1'b0;
      #1;
      check("rst_mid_outs", {pe_start, pe_valid_in, pe_last, pe_a, pe_b, done, err},
            32'd0);
      check("rst_mid_res", {16'd0, res}, 32'd0);
      check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
      exp_beat_q.delete();
      exp_res_q.delete();
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk); clr_n = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      check("rst_no_done", done_cnt - d0, 32'd0);
      run_cmd(16);

      check("spurious", spurious, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pe_stream_feeder.md
PE_STREAM_FEEDER -- requirements
Module: pe_stream_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 4: operand width of a/b.
REQ-002 Parameter ACC_WIDTH, default 16: width of the PE result.
REQ-003 Parameter DEPTH, default 16: maximum vector length K, which is also the operand buffer depth.
REQ-004 Parameter PE_LATENCY, default 3: cycles from the last beat to the PE's output_valid.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 clr_n  in  1  reset, asynchronous, active-low.
REQ-007 wr_en  in  1  operand buffer write strobe.
REQ-008 wr_sel  in  1  write target: 0 = A buffer, 1 = B buffer.
REQ-009 wr_addr  in  $clog2(DEPTH)  buffer write index.
REQ-010 wr_data  in  DATA_WIDTH  buffer write data.
REQ-011 cmd_valid  in  1  request to run one dot product.
REQ-012 cmd_len  in  $clog2(DEPTH)+1  vector length, 0..DEPTH.
REQ-013 cmd_ready  out  1  feeder can accept a command.
REQ-014 hold  in  1  stall request; suppresses beat emission.
REQ-015 pe_start, pe_valid_in, pe_last  out  1 each  PE stream controls.
REQ-016 pe_a, pe_b  out  DATA_WIDTH  PE operands.
REQ-017 pe_c  in  ACC_WIDTH  PE result.
REQ-018 pe_output_valid  in  1  PE result valid.
REQ-019 res  out  ACC_WIDTH  captured result.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  1  sticky watchdog error flag.

Function
REQ-022 FSM states SHALL be IDLE, STREAM and WAIT; cmd_ready SHALL be high only in IDLE.
REQ-023 IDLE: cmd_valid & cmd_ready with cmd_len>0 SHALL latch cmd_len, clear the index and go to STREAM.
REQ-024 cmd_len==0 SHALL stay in IDLE, set res=0, pulse done the next cycle, and emit no beats.
REQ-025 cmd_len>DEPTH SHALL be clamped to DEPTH.
REQ-026 STREAM: each cycle with hold==0 SHALL emit one registered beat: pe_valid_in=1, pe_a=A[idx], pe_b=B[idx], then idx+1.
REQ-027 The first beat SHALL appear the cycle after command acceptance if hold==0.
REQ-028 pe_start SHALL be high only on beat idx 0; pe_last SHALL be high only on beat idx len-1; both SHALL be high on the single beat when len==1.
REQ-029 While hold==1: pe_valid_in, pe_start and pe_last SHALL be 0, idx SHALL be held, and a pending start SHALL remain with the next emitted beat.
REQ-030 Outside emitted beats, pe_valid_in, pe_start and pe_last SHALL be 0, and pe_a/pe_b SHALL keep their last value.
REQ-031 After the last beat the FSM SHALL go to WAIT and clear the watchdog counter.
REQ-032 WAIT: on pe_output_valid==1, res SHALL capture pe_c, done SHALL pulse for 1 cycle in the same cycle res updates, and the FSM SHALL return to IDLE.
REQ-033 pe_output_valid outside WAIT SHALL be ignored.
REQ-034 wr_en SHALL write a buffer only in IDLE; writes while busy SHALL be dropped.
REQ-035 A write and a command accepted in the same cycle: the write SHALL land first and be visible to the stream.
REQ-036 Buffers SHALL retain contents across commands.

Reset
REQ-037 clr_n low SHALL immediately force state IDLE, idx=0, all pe_* outputs 0, res=0, done=0, err=0, watchdog=0.
REQ-038 Buffer contents SHALL NOT be reset.
REQ-039 Reset mid-STREAM or mid-WAIT SHALL abort with no done pulse.
REQ-040 After clr_n rises, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-041 With macro PE_FEEDER_WATCHDOG_EN defined: in WAIT, the watchdog SHALL count cycles, and reaching PE_LATENCY+2 without pe_output_valid SHALL set err (sticky until reset), pulse done with res unchanged, and return to IDLE.
REQ-042 Without PE_FEEDER_WATCHDOG_EN: err SHALL be tied 0, no counter SHALL be built, and WAIT SHALL wait indefinitely.

Structure
REQ-043 State encoding and default parameter constants SHALL live in shared package pe_pkg.
REQ-044 The dual operand buffer SHALL be a sub-module pe_operand_buf: one write port, combinational read of A and B at the same index.

Verification
REQ-045 Load A=B={1..4}, cmd_len=4, hold=0 -> 4 consecutive beats; start on beat 0, last on beat 3; with the PE model, res=0x001E and done pulses once.
REQ-046 cmd_len=1, A[0]=0xF, B[0]=0xF -> a single beat with start=last=1; res=0x00E1.
REQ-047 cmd_len=4 with hold=1 for 2 cycles after beat 1 -> beats 0,1,gap,gap,2,3; start appears once; the result is unchanged.
REQ-048 cmd_len=0 -> no pe_valid_in; done next cycle; res=0.
REQ-049 With PE_FEEDER_WATCHDOG_EN, the PE model never asserts output_valid -> err=1 and done exactly PE_LATENCY+2 cycles after entering WAIT; the next command is accepted.
REQ-050 clr_n asserted at beat 2 of 16 -> all outputs 0 immediately, no done; a re-issued command produces the correct sum.
